// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg: definitions shared by the decode stage and its register file.
//   - datapath widths (XLEN, REG_AW)
//   - primary opcode constants
//   - ctrl_t control-bit bundle and decode_ctrl() opcode-to-control mapping
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic illegal;
    } ctrl_t;

    // Jumps never reach ID/EX, so they carry no control bits here; the
    // decode stage recognises OP_J on its own.
    function automatic ctrl_t decode_ctrl(input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_RTYPE: c.reg_write = 1'b1;
            OP_ADDI:  c.reg_write = 1'b1;
            OP_LW: begin
                c.mem_read  = 1'b1;
                c.reg_write = 1'b1;
            end
            OP_SW:    c.mem_write = 1'b1;
            OP_BEQ:   c.branch    = 1'b1;
            OP_J:     c           = '0;
            default:  c.illegal   = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_regfile.sv
// ---------------------------------------------------------------------------
// regfile: 32 x 32 register file for the decode stage.
//   clk, rst             : clock, synchronous active-high reset (clears all)
//   i_ra/i_rb            : asynchronous read addresses (rs, rt)
//   o_ra_data/o_rb_data  : read data, with write-back bypass; r0 reads 0
//   i_we/i_waddr/i_wdata : synchronous write port; writes to r0 are ignored
// ---------------------------------------------------------------------------
module regfile
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] i_ra,
    input  logic [REG_AW-1:0] i_rb,
    output logic [XLEN-1:0]   o_ra_data,
    output logic [XLEN-1:0]   o_rb_data,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_waddr,
    input  logic [XLEN-1:0]   i_wdata
);

    logic [XLEN-1:0] r_mem [32];
    logic            w_wr;

    assign w_wr = i_we && (i_waddr != '0);

    // NOTE: every entry is cleared on reset, so this array is built from
    // flops rather than a RAM macro; a RAM cannot be reset in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // A write landing in the same cycle as the read is forwarded so the
    // reader never sees the stale value. w_wr already excludes r0.
    assign o_ra_data = (i_ra == '0)               ? '0      :
                       (w_wr && i_waddr == i_ra)  ? i_wdata : r_mem[i_ra];
    assign o_rb_data = (i_rb == '0)               ? '0      :
                       (w_wr && i_waddr == i_rb)  ? i_wdata : r_mem[i_rb];

endmodule

// File: rtl/decode.sv
// ---------------------------------------------------------------------------
// decode: instruction decode stage with a single ID/EX output register.
//   clk, rst                  : clock, synchronous active-high reset
//   in_valid/in_ready         : handshake from fetch (ir_i, npc_i)
//   out_valid/out_ready       : handshake to execute for the ID/EX register
//   flush                     : execute redirect, drops held and incoming work
//   wb_en/wb_addr/wb_data     : register-file write-back port
//   a_o, b_o                  : rs / rt operand values
//   imm_o, rd_o, op_o, funct_o, npc_o : decoded fields
//   reg_write_o .. illegal_o  : control bits
//   pc_update_o, pc_o         : one-cycle jump redirect to fetch
// ---------------------------------------------------------------------------
module decode
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [XLEN-1:0]   ir_i,
    input  logic [XLEN-1:0]   npc_i,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    output logic [XLEN-1:0]   a_o,
    output logic [XLEN-1:0]   b_o,
    output logic [XLEN-1:0]   imm_o,
    output logic [REG_AW-1:0] rd_o,
    output logic [5:0]        op_o,
    output logic [5:0]        funct_o,
    output logic [XLEN-1:0]   npc_o,
    output logic              reg_write_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic              branch_o,
    output logic              illegal_o,
    output logic              pc_update_o,
    output logic [XLEN-1:0]   pc_o
);

    logic [5:0]        w_op;
    logic [REG_AW-1:0] w_rs;
    logic [REG_AW-1:0] w_rt;
    logic [REG_AW-1:0] w_rd;
    logic [XLEN-1:0]   w_imm;
    logic [XLEN-1:0]   w_a;
    logic [XLEN-1:0]   w_b;
    ctrl_t             w_ctrl;
    logic              w_is_j;
    logic              w_stall;
    logic              w_accept;
    logic              w_load;
    logic              w_jump;
    logic              r_squash;

    assign w_op   = ir_i[31:26];
    assign w_rs   = ir_i[25:21];
    assign w_rt   = ir_i[20:16];
    assign w_imm  = {{16{ir_i[15]}}, ir_i[15:0]};
    assign w_ctrl = decode_ctrl(w_op);
    assign w_is_j = (w_op == OP_J);

    // NOTE: w_rd gets a default before the case so every path assigns it;
    // otherwise an unlisted opcode would hold the old value and infer a latch.
    always_comb begin
        w_rd = '0;
        case (w_op)
            OP_RTYPE:      w_rd = ir_i[15:11];
            OP_ADDI, OP_LW: w_rd = w_rt;
            default:       w_rd = '0;
        endcase
    end

    // Load-use hazard: the load in ID/EX has not produced its data yet, so a
    // consumer must wait until the load has left and a bubble has gone by.
    assign w_stall  = out_valid && mem_read_o && (rd_o != '0) &&
                      ((rd_o == w_rs) || (rd_o == w_rt));
    assign in_ready = !w_stall && (!out_valid || out_ready);

    // flush blocks acceptance outright, so it beats stall, jump and load.
    assign w_accept = in_valid && in_ready && !flush;
    // The instruction after an accepted jump is taken off fetch but dropped.
    assign w_load   = w_accept && !r_squash && !w_is_j;
    assign w_jump   = w_accept && !r_squash &&  w_is_j;

    regfile u_regfile (
        .clk       (clk),
        .rst       (rst),
        .i_ra      (w_rs),
        .i_rb      (w_rt),
        .o_ra_data (w_a),
        .o_rb_data (w_b),
        .i_we      (wb_en),
        .i_waddr   (wb_addr),
        .i_wdata   (wb_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            r_squash    <= 1'b0;
            pc_update_o <= 1'b0;
            pc_o        <= '0;
            a_o         <= '0;
            b_o         <= '0;
            imm_o       <= '0;
            rd_o        <= '0;
            op_o        <= '0;
            funct_o     <= '0;
            npc_o       <= '0;
            reg_write_o <= 1'b0;
            mem_read_o  <= 1'b0;
            mem_write_o <= 1'b0;
            branch_o    <= 1'b0;
            illegal_o   <= 1'b0;
        end else begin
            pc_update_o <= w_jump;
            if (w_jump) begin
                pc_o <= {npc_i[31:26], ir_i[25:0]};
            end

            if (flush) begin
                r_squash <= 1'b0;
            end else if (w_accept) begin
                r_squash <= w_jump;
            end

            if (flush) begin
                out_valid <= 1'b0;
            end else if (w_load) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (w_load) begin
                a_o         <= w_a;
                b_o         <= w_b;
                imm_o       <= w_imm;
                rd_o        <= w_rd;
                op_o        <= w_op;
                funct_o     <= ir_i[5:0];
                npc_o       <= npc_i;
                reg_write_o <= w_ctrl.reg_write;
                mem_read_o  <= w_ctrl.mem_read;
                mem_write_o <= w_ctrl.mem_write;
                branch_o    <= w_ctrl.branch;
                illegal_o   <= w_ctrl.illegal;
            end
        end
    end

endmodule

// File: tb/tb_decode.sv
// ---------------------------------------------------------------------------
// tb_decode: directed self-checking bench for the decode stage.
// Inputs change 1 ns after a rising edge; outputs are compared 1 ns after
// an edge (registered) or 1 ns after an input change (in_ready).
// ---------------------------------------------------------------------------
module tb_decode;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] ir_i;
    logic [31:0] npc_i;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] a_o, b_o, imm_o, npc_o, pc_o;
    logic [4:0]  rd_o;
    logic [5:0]  op_o, funct_o;
    logic        reg_write_o, mem_read_o, mem_write_o, branch_o, illegal_o;
    logic        pc_update_o;

    int errors = 0;
    int checks = 0;

    decode dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .ir_i(ir_i), .npc_i(npc_i),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .a_o(a_o), .b_o(b_o), .imm_o(imm_o), .rd_o(rd_o), .op_o(op_o),
        .funct_o(funct_o), .npc_o(npc_o), .reg_write_o(reg_write_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .branch_o(branch_o),
        .illegal_o(illegal_o), .pc_update_o(pc_update_o), .pc_o(pc_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] target);
        return {6'h02, target};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (pc_update_o !== 1'b0) begin errors++; $display("FAIL reset_pc_update: got %b want 0", pc_update_o); end
        checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", pc_o); end
        checks++; if ({a_o, rd_o, reg_write_o} !== '0) begin errors++; $display("FAIL reset_fields: got a=%h rd=%0d rw=%b want 0", a_o, rd_o, reg_write_o); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_writeback();
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h55;
        tick();
        wb_en = 1'b0;
        in_valid = 1'b1; ir_i = enc_r(5'd3, 5'd3, 5'd4, 6'h20); npc_i = 32'h11;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL add_in_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_out_valid: got %b want 1", out_valid); end
        checks++; if (a_o !== 32'h55 || b_o !== 32'h55) begin errors++; $display("FAIL add_operands: got a=%h b=%h want 55 55", a_o, b_o); end
        checks++; if (rd_o !== 5'd4 || reg_write_o !== 1'b1) begin errors++; $display("FAIL add_rd: got rd=%0d rw=%b want 4 1", rd_o, reg_write_o); end
        checks++; if (op_o !== 6'h00 || funct_o !== 6'h20 || npc_o !== 32'h11) begin errors++; $display("FAIL add_fields: got op=%h fn=%h npc=%h want 00 20 11", op_o, funct_o, npc_o); end
        // same-cycle write-back to rs is forwarded
        in_valid = 1'b1; ir_i = enc_r(5'd7, 5'd0, 5'd8, 6'h22);
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h77;
        tick();
        checks++; if (a_o !== 32'h77 || b_o !== 32'h0 || rd_o !== 5'd8) begin errors++; $display("FAIL bypass: got a=%h b=%h rd=%0d want 77 0 8", a_o, b_o, rd_o); end
        // r0 ignores writes and is never forwarded
        wb_addr = 5'd0; wb_data = 32'hFFFF; ir_i = enc_r(5'd0, 5'd0, 5'd9, 6'h20);
        tick();
        checks++; if (a_o !== 32'h0 || b_o !== 32'h0) begin errors++; $display("FAIL r0_bypass: got a=%h b=%h want 0 0", a_o, b_o); end
        wb_en = 1'b0; ir_i = enc_r(5'd0, 5'd3, 5'd10, 6'h20);
        tick();
        in_valid = 1'b0;
        checks++; if (a_o !== 32'h0 || b_o !== 32'h55) begin errors++; $display("FAIL r0_read: got a=%h b=%h want 0 55", a_o, b_o); end
    endtask

    task automatic test_decode();
        in_valid = 1'b1; ir_i = enc_i(OP_ADDI, 5'd1, 5'd2, 16'hFFFD); npc_i = 32'h20;
        tick();
        checks++; if (out_valid !== 1'b1 || rd_o !== 5'd2 || imm_o !== 32'hFFFF_FFFD) begin errors++; $display("FAIL addi: got v=%b rd=%0d imm=%h want 1 2 fffffffd", out_valid, rd_o, imm_o); end
        checks++; if ({reg_write_o, mem_read_o, mem_write_o, branch_o, illegal_o} !== 5'b10000 || op_o !== 6'h08) begin errors++; $display("FAIL addi_ctrl: got %b op=%h want 10000 08", {reg_write_o, mem_read_o, mem_write_o, branch_o, illegal_o}, op_o); end
        ir_i = enc_i(OP_SW, 5'd1, 5'd3, 16'h0008);
        tick();
        checks++; if ({reg_write_o, mem_read_o, mem_write_o, branch_o, illegal_o} !== 5'b00100 || b_o !== 32'h55 || imm_o !== 32'h8) begin errors++; $display("FAIL sw: got ctrl=%b b=%h imm=%h want 00100 55 8", {reg_write_o, mem_read_o, mem_write_o, branch_o, illegal_o}, b_o, imm_o); end
        ir_i = enc_i(OP_BEQ, 5'd3, 5'd3, 16'h0010);
        tick();
        checks++; if ({reg_write_o, mem_read_o, mem_write_o, branch_o, illegal_o} !== 5'b00010 || a_o !== 32'h55 || imm_o !== 32'h10) begin errors++; $display("FAIL beq: got ctrl=%b a=%h imm=%h want 00010 55 10", {reg_write_o, mem_read_o, mem_write_o, branch_o, illegal_o}, a_o, imm_o); end
        ir_i = 32'hFC00_0000;
        tick();
        checks++; if ({reg_write_o, mem_read_o, mem_write_o, branch_o, illegal_o} !== 5'b00001 || out_valid !== 1'b1) begin errors++; $display("FAIL illegal: got ctrl=%b v=%b want 00001 1", {reg_write_o, mem_read_o, mem_write_o, branch_o, illegal_o}, out_valid); end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain: got %b want 0", out_valid); end
    endtask

    task automatic test_load_use();
        in_valid = 1'b1; ir_i = enc_i(OP_LW, 5'd1, 5'd5, 16'h0);
        tick();
        checks++; if (out_valid !== 1'b1 || mem_read_o !== 1'b1 || rd_o !== 5'd5) begin errors++; $display("FAIL lw: got v=%b mr=%b rd=%0d want 1 1 5", out_valid, mem_read_o, rd_o); end
        ir_i = enc_r(5'd5, 5'd2, 5'd6, 6'h20);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL stall_bubble: got v=%b rdy=%b want 0 1", out_valid, in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || rd_o !== 5'd6 || mem_read_o !== 1'b0) begin errors++; $display("FAIL stall_release: got v=%b rd=%0d mr=%b want 1 6 0", out_valid, rd_o, mem_read_o); end
        tick();
    endtask

    task automatic test_jump();
        in_valid = 1'b1; ir_i = enc_j(26'h40); npc_i = 32'h10;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL j_in_ready: got %b want 1", in_ready); end
        tick();
        checks++; if (pc_update_o !== 1'b1 || pc_o !== 32'h40 || out_valid !== 1'b0) begin errors++; $display("FAIL j: got upd=%b pc=%h v=%b want 1 40 0", pc_update_o, pc_o, out_valid); end
        ir_i = enc_i(OP_ADDI, 5'd0, 5'd11, 16'h5); npc_i = 32'h11;
        tick();
        checks++; if (pc_update_o !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL j_squash: got upd=%b v=%b want 0 0", pc_update_o, out_valid); end
        npc_i = 32'h12;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || rd_o !== 5'd11 || imm_o !== 32'h5) begin errors++; $display("FAIL j_after: got v=%b rd=%0d imm=%h want 1 11 5", out_valid, rd_o, imm_o); end
        tick();
    endtask

    task automatic test_back_to_back_stall();
        in_valid = 1'b1; ir_i = enc_i(OP_ADDI, 5'd0, 5'd12, 16'h12);
        tick();
        out_ready = 1'b0; ir_i = enc_i(OP_ADDI, 5'd0, 5'd13, 16'h13);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || rd_o !== 5'd12 || imm_o !== 32'h12 || in_ready !== 1'b0) begin errors++; $display("FAIL hold_%0d: got v=%b rd=%0d imm=%h rdy=%b want 1 12 12 0", i, out_valid, rd_o, imm_o, in_ready); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_release_rdy: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || rd_o !== 5'd13 || imm_o !== 32'h13) begin errors++; $display("FAIL hold_next: got v=%b rd=%0d imm=%h want 1 13 13", out_valid, rd_o, imm_o); end
        tick();
    endtask

    task automatic test_flush();
        in_valid = 1'b1; ir_i = enc_j(26'h3FF_FFFF); npc_i = 32'hA800_0001;
        tick();
        checks++; if (pc_update_o !== 1'b1 || pc_o !== 32'hABFF_FFFF) begin errors++; $display("FAIL j_upper: got upd=%b pc=%h want 1 abffffff", pc_update_o, pc_o); end
        // flush with an addi: nothing enters, write-back still commits
        flush = 1'b1; ir_i = enc_i(OP_ADDI, 5'd0, 5'd16, 16'h1);
        wb_en = 1'b1; wb_addr = 5'd20; wb_data = 32'h1234;
        tick();
        checks++; if (out_valid !== 1'b0 || pc_update_o !== 1'b0) begin errors++; $display("FAIL flush_addi: got v=%b upd=%b want 0 0", out_valid, pc_update_o); end
        // squash was cleared by the flush, so this one enters
        flush = 1'b0; wb_en = 1'b0; ir_i = enc_i(OP_ADDI, 5'd20, 5'd14, 16'h1);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_rdy: got %b want 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || rd_o !== 5'd14 || a_o !== 32'h1234) begin errors++; $display("FAIL flush_after: got v=%b rd=%0d a=%h want 1 14 1234", out_valid, rd_o, a_o); end
        // flush beats a jump and clears the held instruction
        flush = 1'b1; ir_i = enc_j(26'h80); npc_i = 32'h20;
        tick();
        checks++; if (out_valid !== 1'b0 || pc_update_o !== 1'b0 || pc_o !== 32'hABFF_FFFF) begin errors++; $display("FAIL flush_j: got v=%b upd=%b pc=%h want 0 0 abffffff", out_valid, pc_update_o, pc_o); end
        flush = 1'b0; in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_abort();
        out_ready = 1'b0;
        in_valid = 1'b1; ir_i = enc_i(OP_LW, 5'd1, 5'd5, 16'h0);
        tick();
        ir_i = enc_r(5'd5, 5'd2, 5'd6, 6'h20);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL abort_stall_rdy: got %b want 0", in_ready); end
        rst = 1'b1;
        tick();
        rst = 1'b0; out_ready = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || mem_read_o !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL abort_stall: got v=%b mr=%b rdy=%b want 0 0 1", out_valid, mem_read_o, in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || rd_o !== 5'd6) begin errors++; $display("FAIL abort_stall_next: got v=%b rd=%0d want 1 6", out_valid, rd_o); end
        ir_i = enc_j(26'h40); npc_i = 32'h10;
        tick();
        ir_i = enc_i(OP_ADDI, 5'd20, 5'd17, 16'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (pc_update_o !== 1'b0 || pc_o !== 32'h0) begin errors++; $display("FAIL abort_squash_pc: got upd=%b pc=%h want 0 0", pc_update_o, pc_o); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || rd_o !== 5'd17 || a_o !== 32'h0) begin errors++; $display("FAIL abort_squash_next: got v=%b rd=%0d a=%h want 1 17 0", out_valid, rd_o, a_o); end
        tick();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; ir_i = '0; npc_i = '0; out_ready = 1'b1;
        flush = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        test_reset();
        test_writeback();
        test_decode();
        test_load_use();
        test_jump();
        test_back_to_back_stall();
        test_flush();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
